pixel_out_buffer: RTL and testbench

//  Elastic output stage directly downstream of the filter top level. Captures 32-bit

---
 rtl/pixel_out_buffer.sv | 183 ++++++++++++++++++
 tb/tb_pixel_out_buffer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_out_buffer.sv
// ---------------------------------------------------------------------------
// pixel_out_buffer
// Elastic output stage between the filter top level and the PCIe write-DMA.
// Stores 32-bit pixels in a DEPTH-entry FIFO and presents the head entry
// first-word-fall-through on a valid/ready interface. Also reports when a
// full burst is buffered, marks the last pixel of each frame and pulses
// frame_done after that pixel leaves.
//
// Build option:
//   OVERFLOW_FLAG_EN - when defined, a sticky overflow flag records any
//                      write attempted while full (cleared by overflow_clr).
//                      When undefined, overflow is tied low and no flop exists.
// ---------------------------------------------------------------------------
module pixel_out_buffer #(
    parameter int DEPTH        = 16,
    parameter int BURST_LEN    = 8,
    parameter int FRAME_PIXELS = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [31:0]              in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [31:0]              out_data,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     burst_avail,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frame_done,
    output logic                     overflow,
    input  logic                     overflow_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CTR_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_BURST = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_ONE   = CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_ZERO  = CTR_W'(0);
    localparam logic [CTR_W-1:0] CTR_LAST  = CTR_W'(FRAME_PIXELS - 1);

    // Storage and state
    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_out_data;
    logic [CTR_W-1:0] r_pix_ctr;
    logic             r_frame_done;

    // Derived handshake terms
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_last;
    logic [PTR_W-1:0] w_rd_ptr_inc;
    logic [31:0]      w_head_nxt;
    logic [CNT_W-1:0] w_count_nxt;

    // Status decode from the registered occupancy; pointers alone cannot tell full from empty.
    assign w_full       = (r_count == CNT_DEPTH);
    assign w_empty      = (r_count == CNT_ZERO);
    assign w_push       = in_valid && !w_full;
    assign w_pop        = !w_empty && out_ready;
    assign w_last       = !w_empty && (r_pix_ctr == CTR_LAST);
    assign w_rd_ptr_inc = r_rd_ptr + PTR_ONE;

    // Select what the head register shows after this edge (FWFT, no same-cycle bypass).
    always_comb begin
        w_head_nxt = r_out_data;
        if (w_pop) begin
            if (r_count == CNT_ONE) begin
                // Only entry leaves; a simultaneous write becomes the new head.
                if (w_push) begin
                    w_head_nxt = in_data;
                end else begin
                    w_head_nxt = r_out_data;
                end
            end else begin
                // At least two entries: the one behind the head is already in memory.
                w_head_nxt = r_mem[w_rd_ptr_inc];
            end
        end else if (w_empty && w_push) begin
            w_head_nxt = in_data;
        end else begin
            w_head_nxt = r_out_data;
        end
    end

    // Occupancy update: +1 on write only, -1 on read only, unchanged otherwise.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage array; contents are not reset, stale data is unreachable after reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointer, occupancy and head-register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_out_data <= 32'h0000_0000;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            r_count    <= w_count_nxt;
            r_out_data <= w_head_nxt;
        end
    end

    // Read-side pixel counter with frame wrap and a one-cycle frame_done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_ctr    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_pop && w_last;
            if (w_pop) begin
                if (w_last) begin
                    r_pix_ctr <= CTR_ZERO;
                end else begin
                    r_pix_ctr <= r_pix_ctr + CTR_ONE;
                end
            end
        end
    end

`ifdef OVERFLOW_FLAG_EN
    logic r_overflow;

    // Sticky overflow: a new dropped write takes priority over a clear request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (in_valid && w_full) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    assign overflow = r_overflow;
`else
    logic w_unused_overflow_clr;

    assign w_unused_overflow_clr = overflow_clr;
    assign overflow              = 1'b0;
`endif

    // Output mapping
    assign in_ready    = !w_full;
    assign out_valid   = !w_empty;
    assign out_data    = r_out_data;
    assign out_last    = w_last;
    assign burst_avail = (r_count >= CNT_BURST);
    assign count       = r_count;
    assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_pixel_out_buffer.sv
// ---------------------------------------------------------------------------
// tb_pixel_out_buffer
// Directed self-checking bench for pixel_out_buffer with DEPTH=16,
// BURST_LEN=8, FRAME_PIXELS=4. Inputs change 1 time unit after the rising
// edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_pixel_out_buffer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        out_last;
    logic        burst_avail;
    logic [4:0]  count;
    logic        frame_done;
    logic        overflow;
    logic        overflow_clr;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_head;

    pixel_out_buffer #(
        .DEPTH        (16),
        .BURST_LEN    (8),
        .FRAME_PIXELS (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .burst_avail  (burst_avail),
        .count        (count),
        .frame_done   (frame_done),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = 32'h0;
        out_ready    = 1'b0;
        overflow_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_burst", 32'(burst_avail), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // Test 1: single write, one-cycle latency
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        step();
        in_valid = 1'b0;
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_data", out_data, 32'hDEAD_BEEF);
        chk("t1_count", 32'(count), 32'd1);
        chk("t1_burst", 32'(burst_avail), 32'd0);

        // Test 2: fill to burst threshold, then to full
        for (int i = 1; i <= 7; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h0000_1000 + 32'(i);
            step();
            if (i == 6) chk("t2_burst_at7", 32'(burst_avail), 32'd0);
        end
        chk("t2_count8", 32'(count), 32'd8);
        chk("t2_burst_at8", 32'(burst_avail), 32'd1);
        for (int i = 0; i < 8; i++) begin
            in_data = 32'h0000_2000 + 32'(i);
            step();
            if (i == 6) chk("t2_in_ready_at15", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        chk("t2_count16", 32'(count), 32'd16);
        chk("t2_in_ready_full", 32'(in_ready), 32'd0);
        chk("t2_head_stable", out_data, 32'hDEAD_BEEF);

        // Test 3: full, write and read together -> pop only
        in_valid  = 1'b1;
        in_data   = 32'hBAD0_BAD0;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t3_count15", 32'(count), 32'd15);
        chk("t3_head", out_data, 32'h0000_1001);
`ifdef OVERFLOW_FLAG_EN
        chk("t3_overflow", 32'(overflow), 32'd1);
`else
        chk("t3_overflow", 32'(overflow), 32'd0);
`endif
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("t3_overflow_clr", 32'(overflow), 32'd0);

        // Drain to count=5, checking order
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            exp_head = (k < 7) ? (32'h0000_1001 + 32'(k)) : (32'h0000_2000 + 32'(k - 7));
            chk("drain_head", out_data, exp_head);
            step();
        end
        out_ready = 1'b0;
        chk("drain_count5", 32'(count), 32'd5);
        chk("drain_head_after", out_data, 32'h0000_2003);
        chk("drain_out_last", 32'(out_last), 32'd1);

        // Test 4: streaming at count=5, order preserved, count constant
        for (int i = 3; i < 8; i++) exp_q.push_back(32'h0000_2000 + 32'(i));
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 32'h0000_3000 + 32'(i);
            exp_q.push_back(in_data);
            exp_head = exp_q.pop_front();
            chk("t4_order", out_data, exp_head);
            step();
            chk("t4_count", 32'(count), 32'd5);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t4_head_after", out_data, 32'h0000_300F);

        // Test 6: reset mid-stream at count=9
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'h0000_4000 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        chk("t6_count9", 32'(count), 32'd9);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_data", out_data, 32'd0);
        chk("t6_async_count", 32'(count), 32'd0);
        chk("t6_async_burst", 32'(burst_avail), 32'd0);
        chk("t6_async_last", 32'(out_last), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("t6_post_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        in_data  = 32'hCAFE_0001;
        step();
        in_valid = 1'b0;
        chk("t6_reappear_valid", 32'(out_valid), 32'd1);
        chk("t6_reappear_data", out_data, 32'hCAFE_0001);
        chk("t6_reappear_count", 32'(count), 32'd1);

        // Test 5: frame of 4 pixels, 8 pixels streamed (first is CAFE0001)
        in_valid = 1'b1;
        for (int i = 1; i < 8; i++) begin
            in_data = 32'h0000_5000 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        chk("t5_count8", 32'(count), 32'd8);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_head = (k == 0) ? 32'hCAFE_0001 : (32'h0000_5000 + 32'(k));
            chk("t5_head", out_data, exp_head);
            chk("t5_out_last", 32'(out_last), ((k == 3) || (k == 7)) ? 32'd1 : 32'd0);
            step();
            chk("t5_frame_done", 32'(frame_done), ((k == 3) || (k == 7)) ? 32'd1 : 32'd0);
        end
        // Empty: out_ready ignored, out_data holds last value
        step();
        out_ready = 1'b0;
        chk("t5_empty_count", 32'(count), 32'd0);
        chk("t5_empty_valid", 32'(out_valid), 32'd0);
        chk("t5_empty_hold", out_data, 32'h0000_5007);
        chk("t5_empty_last", 32'(out_last), 32'd0);
        chk("t5_fd_low", 32'(frame_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
